// File: rtl/byte_unstriping_pkg.sv
// Shared byte-striping definitions: K-code values and the framer state encoding.
// Reused by the striper, the unstriper and their benches.
package byte_striping_defs;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } frame_state_t;

    function automatic logic is_start(input logic [7:0] code);
        return (code == STP) || (code == SDP);
    endfunction

    function automatic logic is_close(input logic [7:0] code);
        return (code == END) || (code == EDB);
    endfunction

    function automatic logic is_filler(input logic [7:0] code);
        return (code == COM) || (code == SKP) || (code == IDL);
    endfunction

endpackage

// File: rtl/byte_unstriping_if.sv
// Lane-word input handshake plus the reassembled byte stream of the unstriper.
interface byte_unstriping_if #(
    parameter int LANES = 4,
    parameter int BITS  = 8
);
    // A lane word transfers on a rising CLK edge where LANE_VALID & READY are
    // both high; with READY low the lane inputs are ignored. The output stream
    // (D/DK/VALID) has no backpressure: the consumer takes every VALID byte.
    logic [BITS-1:0]  LANE0;
    logic [BITS-1:0]  LANE1;
    logic [BITS-1:0]  LANE2;
    logic [BITS-1:0]  LANE3;
    logic [LANES-1:0] LANE_K;
    logic             LANE_VALID;
    logic             READY;
    logic [BITS-1:0]  D;
    logic             DK;
    logic             VALID;
    logic             IN_PKT;
    logic             FRAME_ERR;

    modport master (
        output LANE0, LANE1, LANE2, LANE3, LANE_K, LANE_VALID,
        input  READY, D, DK, VALID, IN_PKT, FRAME_ERR
    );

    modport slave (
        input  LANE0, LANE1, LANE2, LANE3, LANE_K, LANE_VALID,
        output READY, D, DK, VALID, IN_PKT, FRAME_ERR
    );

endinterface

// File: rtl/byte_unstriping_framer.sv
// Packet framing tracker for the rebuilt byte stream: STP/SDP open, END/EDB close.
// Sees each byte in the same cycle it is registered onto D, so FRAME_ERR lines up with it.
module byte_unstriping_framer
    import byte_striping_defs::*;
#(
    parameter int BITS = 8
) (
    input  logic            CLK,
    input  logic            RESET_L,
    input  logic [BITS-1:0] byte_d,
    input  logic            byte_k,
    input  logic            byte_valid,
    output frame_state_t    state,
    output logic            frame_err
);
    frame_state_t state_next;
    logic         err_next;
    logic [7:0]   code;

    assign code = 8'(byte_d);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state     <= IDLE;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        if (byte_valid) begin
            if (!byte_k) begin
                // Payload is only legal between a start and a close.
                err_next = (state == IDLE);
            end else if (is_start(code)) begin
                if (state == IDLE) begin
                    state_next = PKT;
                end else begin
                    err_next = 1'b1;
                end
            end else if (is_close(code)) begin
                if (state == PKT) begin
                    state_next = IDLE;
                end else begin
                    err_next = 1'b1;
                end
            end else if (!is_filler(code)) begin
                err_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_unstriping.sv
// Reassembles one 4-lane word per handshake into a byte stream, LANE0 first.
// Optional BYTE_UNSTRIPING_IDL_DROP_EN: K-coded IDL bytes keep their slot but are not emitted.
module byte_unstriping
    import byte_striping_defs::*;
#(
    parameter int LANES = 4,
    parameter int BITS  = 8
) (
    input  logic             CLK,
    input  logic             RESET_L,
    byte_unstriping_if.slave bus
);
    localparam logic [1:0] LAST_IDX = 2'(LANES - 1);

    logic [LANES-1:0] lane_k;
    logic [BITS-1:0]  hold_d [LANES-1];
    logic [LANES-2:0] hold_k;
    logic [1:0]       idx;
    logic             full;

    logic             ready;
    logic             take;
    logic             emit;
    logic [BITS-1:0]  emit_d;
    logic             emit_k;
    logic             drop;

    logic [BITS-1:0]  d_q;
    logic             dk_q;
    logic             valid_q;
    logic [BITS-1:0]  d_next;
    logic             dk_next;
    logic             valid_next;

    frame_state_t     fstate;
    logic             frame_err;

    assign lane_k = bus.LANE_K;

    // idx is the lane index of the byte currently on D; hold_d[n] keeps lane n+1.
    always_comb begin
        ready  = ~full | (idx == LAST_IDX);
        take   = bus.LANE_VALID & ready;
        emit   = 1'b0;
        emit_d = d_q;
        emit_k = dk_q;
        if (take) begin
            emit   = 1'b1;
            emit_d = bus.LANE0;
            emit_k = lane_k[0];
        end else if (full && (idx != LAST_IDX)) begin
            emit   = 1'b1;
            emit_d = hold_d[idx];
            emit_k = hold_k[idx];
        end
    end

`ifdef BYTE_UNSTRIPING_IDL_DROP_EN
    assign drop = emit & emit_k & (emit_d == BITS'(IDL));
`else
    assign drop = 1'b0;
`endif

    // A dropped byte still consumes its slot; D/DK simply hold.
    assign valid_next = emit & ~drop;
    assign d_next     = valid_next ? emit_d : d_q;
    assign dk_next    = valid_next ? emit_k : dk_q;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            full    <= 1'b0;
            idx     <= 2'd0;
            hold_d  <= '{default: '0};
            hold_k  <= '0;
            d_q     <= '0;
            dk_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_next;
            dk_q    <= dk_next;
            valid_q <= valid_next;
            if (take) begin
                hold_d[0] <= bus.LANE1;
                hold_d[1] <= bus.LANE2;
                hold_d[2] <= bus.LANE3;
                hold_k    <= lane_k[LANES-1:1];
                idx       <= 2'd0;
                full      <= 1'b1;
            end else if (full) begin
                if (idx == LAST_IDX) begin
                    full <= 1'b0;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

    byte_unstriping_framer #(
        .BITS(BITS)
    ) u_framer (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .byte_d     (d_next),
        .byte_k     (dk_next),
        .byte_valid (valid_next),
        .state      (fstate),
        .frame_err  (frame_err)
    );

    assign bus.READY     = ready;
    assign bus.D         = d_q;
    assign bus.DK        = dk_q;
    assign bus.VALID     = valid_q;
    assign bus.IN_PKT    = (fstate == PKT);
    assign bus.FRAME_ERR = frame_err;

endmodule
